fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction-fetch controller that owns the program counter and sequences the instruction-memory request/response handshake.
- Presents one fetched instruction at a time to decode, using a valid/ready handshake.
- Accepts PC redirects from execute: branch_unit's taken decision or a jump, with the target already computed.
- Squashes wrong-path fetches in flight and flags misaligned redirect targets.

Parameters:
XLEN, 32, address/PC width
RESET_VEC, 32'h0000_0000, PC fetched first after reset

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous active-high reset
imem_req_o  out  1  fetch request valid
imem_addr_o  out  XLEN  fetch address (current PC)
imem_gnt_i  in  1  memory accepts request this cycle
imem_rvalid_i  in  1  response valid (exactly one per granted request, >=1 cycle after gnt)
imem_rdata_i  in  32  response instruction word
instr_valid_o  out  1  instruction available to decode
instr_o  out  32  held instruction
instr_pc_o  out  XLEN  PC of held instruction
instr_ready_i  in  1  decode consumes instruction
redirect_i  in  1  redirect PC (branch taken / jump)
redirect_pc_i  in  XLEN  redirect target
exc_misaligned_o  out  1  one-cycle pulse: redirect target[1:0]!=0
fetch_count_o  out  32  count of instr_valid_o && instr_ready_i handshakes
flush_count_o  out  32  count of squashed fetches/instructions

Behaviour:
- Reset:
  - rst_i high -> state ST_BOOT, pc=RESET_VEC, all outputs 0, both counters 0.
  - Memory shares rst_i: no response is outstanding after reset.
- Reset mid-operation: outstanding work is abandoned; the reset values above apply on the next edge.
- States: ST_BOOT, ST_REQ, ST_WAIT, ST_HOLD, ST_DRAIN, ST_HALT. Transitions:
  - ST_BOOT: outputs 0; next cycle -> ST_REQ. Result: first request is issued 1 cycle after rst_i falls.
  - ST_REQ: imem_req_o=1, imem_addr_o=pc; on imem_gnt_i -> ST_WAIT.
  - ST_WAIT: on imem_rvalid_i, latch imem_rdata_i into instr_o and pc into instr_pc_o -> ST_HOLD.
  - ST_HOLD: instr_valid_o=1. instr_o and instr_pc_o are stable while instr_ready_i=0. On handshake, pc<=pc+4 (mod 2^XLEN) and fetch_count_o increments -> ST_REQ.
  - ST_DRAIN: waits for the one outstanding response; on imem_rvalid_i, discard the data -> ST_REQ.
  - ST_HALT: all handshake outputs 0 until reset; redirect_i is ignored.
- Throughput: one instruction per 3 cycles with zero-wait memory and decode.
- Redirect (redirect_i=1, target aligned) has priority over every normal transition except in ST_BOOT/ST_HALT. In all cases pc<=redirect_pc_i. Per state:
  - ST_REQ, no gnt: stay ST_REQ. The address may change while ungranted.
  - ST_REQ with gnt the same cycle: -> ST_DRAIN, flush_count_o +1.
  - ST_WAIT, no rvalid: -> ST_DRAIN, flush_count_o +1.
  - ST_WAIT with rvalid the same cycle: data discarded -> ST_REQ, flush_count_o +1.
  - ST_HOLD: instr_valid_o = (state==ST_HOLD) && !redirect_i. The held instruction is squashed even if instr_ready_i=1: no handshake, fetch_count_o unchanged, flush_count_o +1 -> ST_REQ.
  - ST_DRAIN: pc updated, stay ST_DRAIN. flush_count_o is not incremented again.
- Misaligned redirect (redirect_i && redirect_pc_i[1:0]!=0):
  - exc_misaligned_o pulses 1 cycle and the state goes to ST_HALT. pc is not updated.
  - If a response is outstanding, it is still absorbed silently in ST_HALT.
- Counters are 32-bit and wrap silently from 0xFFFF_FFFF to 0.
- imem_rvalid_i outside ST_WAIT/ST_DRAIN/ST_HALT is a protocol violation. Add an assertion for it.

Decomposition:
- riscv_pkg gains:
  - fetch_state_e enum (6 states above)
  - INSTR_BYTES=4
  - RESET_VEC default constant
- Sub-module: fetch_counter (32-bit wrap counter with synchronous reset and enable), instantiated twice.
- FSM, PC register and instruction holding register stay in fetch_sequencer.

Test Plan:
- Boot: release rst_i -> imem_req_o=1, addr=0x0 on the 2nd cycle. Gnt, then rvalid with 0x00500093 -> instr_valid_o=1, instr_o=0x00500093, instr_pc_o=0x0. Ready -> next addr=0x4, fetch_count_o=1.
- Backpressure: instr_ready_i=0 for 5 cycles in ST_HOLD -> instr_o/instr_pc_o stable, imem_req_o=0, fetch_count_o unchanged. Then ready=1 -> addr=pc+4.
- Redirect in ST_WAIT to 0x100, rvalid 2 cycles later with 0xDEADBEEF -> no instr_valid_o, next addr=0x100, flush_count_o=1.
- Redirect to 0x40 same cycle as gnt for addr 0x8 -> ST_DRAIN, response dropped, next request addr=0x40. Second redirect to 0x80 during drain -> request addr=0x80, flush_count_o=1.
- Redirect to 0x200 in ST_HOLD with instr_ready_i=1 -> instr_valid_o=0 that cycle, fetch_count_o unchanged, next addr=0x200.
- Redirect to 0x102 -> exc_misaligned_o high exactly 1 cycle, imem_req_o=0 for 20 cycles. rst_i pulse -> fetch restarts at 0x0, counters 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants.
package riscv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned INSTR_W      = 32;
  localparam int unsigned CNT_W        = 32;
  localparam int unsigned INSTR_BYTES  = 4;
  localparam logic [XLEN_DEFAULT-1:0] RESET_VEC_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_HALT  = 3'd5
  } fetch_state_e;

  // A redirect target must be word aligned.
  function automatic logic is_misaligned(input logic [1:0] lo_bits);
    return lo_bits != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_counter.sv
// Free-running event counter: synchronous clear, enable, silent wrap.
module fetch_counter
  import riscv_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Count one per enabled cycle, wrapping at the top.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, runs the imem handshake,
// holds one instruction for decode and squashes wrong-path fetches.
module fetch_sequencer
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN      = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEFAULT)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic               imem_req_o,
  output logic [XLEN-1:0]    imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               instr_valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [XLEN-1:0]    instr_pc_o,
  input  logic               instr_ready_i,
  input  logic               redirect_i,
  input  logic [XLEN-1:0]    redirect_pc_i,
  output logic               exc_misaligned_o,
  output logic [CNT_W-1:0]   fetch_count_o,
  output logic [CNT_W-1:0]   flush_count_o
);

  fetch_state_e       r_state;
  fetch_state_e       w_next_state;
  logic [XLEN-1:0]    r_pc;
  logic [XLEN-1:0]    w_pc_next;
  logic [INSTR_W-1:0] r_instr;
  logic [XLEN-1:0]    r_instr_pc;
  logic               r_exc;
  logic               w_exc_next;
  logic               w_latch;
  logic               w_fetch_inc;
  logic               w_flush_inc;
  logic               w_req;
  logic               w_valid;
  logic [XLEN-1:0]    w_addr;
  logic               w_redir_ok;
  logic               w_redir_bad;

  assign w_redir_bad = redirect_i && is_misaligned(redirect_pc_i[1:0]);
  assign w_redir_ok  = redirect_i && !is_misaligned(redirect_pc_i[1:0]);

  // State, PC, held instruction and exception pulse registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_BOOT;
      r_pc       <= RESET_VEC;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_exc      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_pc_next;
      r_exc   <= w_exc_next;
      if (w_latch) begin
        r_instr    <= imem_rdata_i;
        r_instr_pc <= r_pc;
      end
    end
  end

  // Next-state, PC update and handshake outputs; redirects win over normal flow.
  always_comb begin
    w_next_state = r_state;
    w_pc_next    = r_pc;
    w_exc_next   = 1'b0;
    w_latch      = 1'b0;
    w_fetch_inc  = 1'b0;
    w_flush_inc  = 1'b0;
    w_req        = 1'b0;
    w_valid      = 1'b0;
    w_addr       = '0;
    case (r_state)
      ST_BOOT: begin
        w_next_state = ST_REQ;
      end
      ST_REQ: begin
        w_req  = 1'b1;
        w_addr = r_pc;
        if (w_redir_bad) begin
          w_exc_next   = 1'b1;
          w_next_state = ST_HALT;
        end else if (w_redir_ok) begin
          w_pc_next = redirect_pc_i;
          if (imem_gnt_i) begin
            w_flush_inc  = 1'b1;
            w_next_state = ST_DRAIN;
          end
        end else if (imem_gnt_i) begin
          w_next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_redir_bad) begin
          w_exc_next   = 1'b1;
          w_next_state = ST_HALT;
        end else if (w_redir_ok) begin
          w_pc_next    = redirect_pc_i;
          w_flush_inc  = 1'b1;
          w_next_state = imem_rvalid_i ? ST_REQ : ST_DRAIN;
        end else if (imem_rvalid_i) begin
          w_latch      = 1'b1;
          w_next_state = ST_HOLD;
        end
      end
      ST_HOLD: begin
        w_valid = !redirect_i;
        if (w_redir_bad) begin
          w_exc_next   = 1'b1;
          w_next_state = ST_HALT;
        end else if (w_redir_ok) begin
          w_pc_next    = redirect_pc_i;
          w_flush_inc  = 1'b1;
          w_next_state = ST_REQ;
        end else if (instr_ready_i) begin
          w_pc_next    = r_pc + XLEN'(INSTR_BYTES);
          w_fetch_inc  = 1'b1;
          w_next_state = ST_REQ;
        end
      end
      ST_DRAIN: begin
        if (w_redir_bad) begin
          w_exc_next   = 1'b1;
          w_next_state = ST_HALT;
        end else begin
          if (w_redir_ok) begin
            w_pc_next = redirect_pc_i;
          end
          if (imem_rvalid_i) begin
            w_next_state = ST_REQ;
          end
        end
      end
      ST_HALT: begin
        w_next_state = ST_HALT;
      end
      default: begin
        w_next_state = ST_BOOT;
      end
    endcase
  end

  fetch_counter #(.WIDTH(CNT_W)) u_fetch_cnt (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_en    (w_fetch_inc),
    .o_count (fetch_count_o)
  );

  fetch_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_en    (w_flush_inc),
    .o_count (flush_count_o)
  );

  assign imem_req_o       = w_req;
  assign imem_addr_o      = w_addr;
  assign instr_valid_o    = w_valid;
  assign instr_o          = r_instr;
  assign instr_pc_o       = r_instr_pc;
  assign exc_misaligned_o = r_exc;

  // A response may only arrive while one can be outstanding.
  a_rvalid_legal : assert property (@(posedge clk_i) disable iff (rst_i)
    imem_rvalid_i |-> ((r_state == ST_WAIT) || (r_state == ST_DRAIN) || (r_state == ST_HALT)));

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: vector table plus hand sequences.
module tb_fetch_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        exc_misaligned_o;
  logic [31:0] fetch_count_o;
  logic [31:0] flush_count_o;

  fetch_sequencer dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .imem_gnt_i       (imem_gnt_i),
    .imem_rvalid_i    (imem_rvalid_i),
    .imem_rdata_i     (imem_rdata_i),
    .instr_valid_o    (instr_valid_o),
    .instr_o          (instr_o),
    .instr_pc_o       (instr_pc_o),
    .instr_ready_i    (instr_ready_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .exc_misaligned_o (exc_misaligned_o),
    .fetch_count_o    (fetch_count_o),
    .flush_count_o    (flush_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] data;
    int          gw;
    int          rw;
    int          dw;
  } vec_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[6];
  int          n_cmp = 0;
  int          n_mis = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_fetch;
  logic [31:0] exp_flush;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance to just after the next falling edge.
  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (imem_req_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("req_seen", 32'(imem_req_o), 32'd1);
  endtask

  // One full fetch: wait gw cycles before gnt, rw before rvalid, dw before ready.
  task automatic fetch_one(input logic [31:0] data, input int gw, input int rw, input int dw);
    exp_t e;
    wait_req();
    chk("fetch_addr", imem_addr_o, exp_pc);
    for (int i = 0; i < gw; i++) begin
      tick();
      chk("req_held", 32'(imem_req_o), 32'd1);
    end
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    for (int i = 0; i < rw; i++) tick();
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = data;
    sb.push_back('{instr: data, pc: exp_pc});
    tick();
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    e = sb[0];
    for (int i = 0; i < dw; i++) begin
      chk("bp_instr", instr_o, e.instr);
      chk("bp_pc", instr_pc_o, e.pc);
      chk("bp_req", 32'(imem_req_o), 32'd0);
      chk("bp_fetch_cnt", fetch_count_o, exp_fetch);
      tick();
    end
    chk("hold_valid", 32'(instr_valid_o), 32'd1);
    e = sb.pop_front();
    chk("hold_instr", instr_o, e.instr);
    chk("hold_pc", instr_pc_o, e.pc);
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    exp_pc    = exp_pc + 32'd4;
    exp_fetch = exp_fetch + 32'd1;
    chk("fetch_cnt", fetch_count_o, exp_fetch);
  endtask

  initial begin
    int exc_cnt;
    int req_cnt;
    int val_cnt;

    vecs[0] = '{data: 32'h0050_0093, gw: 0, rw: 0, dw: 0};
    vecs[1] = '{data: 32'h0010_0113, gw: 1, rw: 0, dw: 5};
    vecs[2] = '{data: 32'hCAFE_0001, gw: 0, rw: 2, dw: 0};
    vecs[3] = '{data: 32'h1234_5678, gw: 3, rw: 1, dw: 1};
    vecs[4] = '{data: 32'h8000_0013, gw: 0, rw: 0, dw: 2};
    vecs[5] = '{data: 32'hFFFF_FFFF, gw: 2, rw: 3, dw: 0};

    rst_i = 1'b1;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    instr_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    exp_pc = 32'h0; exp_fetch = 32'h0; exp_flush = 32'h0;

    repeat (3) tick();
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_fetch_cnt", fetch_count_o, 32'd0);
    chk("rst_flush_cnt", flush_count_o, 32'd0);
    chk("rst_exc", 32'(exc_misaligned_o), 32'd0);

    // Boot cycle has no request; the next one does.
    rst_i = 1'b0;
    #1;
    chk("boot_req", 32'(imem_req_o), 32'd0);
    tick();
    chk("first_req", 32'(imem_req_o), 32'd1);
    chk("first_addr", imem_addr_o, 32'h0);

    // Table part A: boot fetch, then backpressure.
    for (int i = 0; i < 2; i++) fetch_one(vecs[i].data, vecs[i].gw, vecs[i].rw, vecs[i].dw);

    // Redirect with gnt for 0x8, then a second redirect while draining.
    wait_req();
    chk("gr_addr", imem_addr_o, 32'h8);
    imem_gnt_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h40;
    tick();
    imem_gnt_i = 1'b0; redirect_i = 1'b0;
    exp_flush = exp_flush + 32'd1;
    chk("drain_req", 32'(imem_req_o), 32'd0);
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h80;
    tick();
    redirect_i = 1'b0;
    chk("drain_req2", 32'(imem_req_o), 32'd0);
    chk("drain_flush", flush_count_o, exp_flush);
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h1111_2222;
    tick();
    imem_rvalid_i = 1'b0;
    chk("drain_valid", 32'(instr_valid_o), 32'd0);
    chk("drain_addr", imem_addr_o, 32'h80);
    chk("drain_flush2", flush_count_o, exp_flush);
    exp_pc = 32'h80;

    // Redirect while waiting; response arrives two cycles later and is dropped.
    wait_req();
    chk("wr_addr", imem_addr_o, 32'h80);
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    tick();
    redirect_i = 1'b0;
    exp_flush = exp_flush + 32'd1;
    tick();
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    chk("wr_valid", 32'(instr_valid_o), 32'd0);
    tick();
    imem_rvalid_i = 1'b0;
    chk("wr_valid2", 32'(instr_valid_o), 32'd0);
    chk("wr_addr2", imem_addr_o, 32'h100);
    chk("wr_flush", flush_count_o, exp_flush);
    exp_pc = 32'h100;

    // Table part B: assorted wait patterns from 0x100.
    for (int i = 2; i < 6; i++) fetch_one(vecs[i].data, vecs[i].gw, vecs[i].rw, vecs[i].dw);

    // Redirect in HOLD with ready high squashes the held instruction.
    wait_req();
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0BAD_0BAD;
    sb.push_back('{instr: 32'h0BAD_0BAD, pc: exp_pc});
    tick();
    imem_rvalid_i = 1'b0;
    chk("hr_valid_pre", 32'(instr_valid_o), 32'd1);
    instr_ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h200;
    #1;
    chk("hr_valid", 32'(instr_valid_o), 32'd0);
    tick();
    instr_ready_i = 1'b0; redirect_i = 1'b0;
    void'(sb.pop_front());
    exp_flush = exp_flush + 32'd1;
    chk("hr_fetch_cnt", fetch_count_o, exp_fetch);
    chk("hr_flush", flush_count_o, exp_flush);
    chk("hr_addr", imem_addr_o, 32'h200);

    // Ungranted redirect in REQ retargets to the top word; PC then wraps to 0.
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    chk("rq_flush", flush_count_o, exp_flush);
    exp_pc = 32'hFFFF_FFFC;
    fetch_one(32'h0000_0013, 0, 0, 0);
    wait_req();
    chk("wrap_addr", imem_addr_o, 32'h0);

    // Misaligned redirect: one-cycle exception, then halted (redirects ignored).
    redirect_i = 1'b1; redirect_pc_i = 32'h102;
    tick();
    redirect_i = 1'b0;
    chk("mis_exc", 32'(exc_misaligned_o), 32'd1);
    chk("mis_req", 32'(imem_req_o), 32'd0);
    exc_cnt = 0; req_cnt = 0; val_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      redirect_i    = (i == 5);
      redirect_pc_i = 32'h300;
      tick();
      if (exc_misaligned_o) exc_cnt++;
      if (imem_req_o) req_cnt++;
      if (instr_valid_o) val_cnt++;
    end
    redirect_i = 1'b0;
    chk("halt_exc_cycles", 32'(exc_cnt), 32'd0);
    chk("halt_req_cycles", 32'(req_cnt), 32'd0);
    chk("halt_valid_cycles", 32'(val_cnt), 32'd0);

    // Reset pulse restarts fetch from the reset vector with cleared counters.
    rst_i = 1'b1;
    tick();
    tick();
    chk("rr_fetch_cnt", fetch_count_o, 32'd0);
    chk("rr_flush_cnt", flush_count_o, 32'd0);
    chk("rr_req", 32'(imem_req_o), 32'd0);
    rst_i = 1'b0;
    exp_pc = 32'h0; exp_fetch = 32'h0; exp_flush = 32'h0;
    #1;
    chk("rr_boot_req", 32'(imem_req_o), 32'd0);
    tick();
    chk("rr_req2", 32'(imem_req_o), 32'd1);
    chk("rr_addr", imem_addr_o, 32'h0);
    fetch_one(32'h0050_0093, 0, 0, 0);

    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
